// File: rtl/npu_bus_arbiter.sv
// ---------------------------------------------------------------------------
// npu_bus_arbiter
//
// Grants ownership of the NPU's shared 32-bit data bus to one requester at a
// time: the host (fixed highest priority) or one of NUM_PE processing
// elements (round-robin among themselves). A grant lasts for a multi-beat
// burst. Every change of owner passes through one dead TURN cycle so that
// the tristate drivers of two owners never overlap.
//
// Optional feature macro: NPU_ARB_TIMEOUT_EN
//   defined   -> a beat counter forces release after TIMEOUT beats without
//                last, pulses timeout_err_o and latches timeout_id_o.
//   undefined -> grants are unbounded, timeout_err_o = 0, timeout_id_o = 15.
//
// Ports
//   clk           clock
//   rst           asynchronous, active-high reset
//   host_req_i    host bus request, held for the whole burst
//   host_last_i   host final-beat flag
//   pe_req_i      per-PE bus request, held for the whole burst
//   pe_last_i     per-PE final-beat flag
//   host_gnt_o    host owns the bus
//   pe_gnt_o      one-hot PE ownership (drives PE output enables)
//   owner_id_o    0..NUM_PE-1 = PE, 8 = host, 15 = no owner
//   busy_o        high while in GRANT or TURN
//   timeout_err_o one-cycle pulse on a forced release
//   timeout_id_o  owner_id of the last forced-release victim
// ---------------------------------------------------------------------------
module npu_bus_arbiter #(
  parameter int NUM_PE  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_req_i,
  input  logic              host_last_i,
  input  logic [NUM_PE-1:0] pe_req_i,
  input  logic [NUM_PE-1:0] pe_last_i,
  output logic              host_gnt_o,
  output logic [NUM_PE-1:0] pe_gnt_o,
  output logic [3:0]        owner_id_o,
  output logic              busy_o,
  output logic              timeout_err_o,
  output logic [3:0]        timeout_id_o
);

  localparam int PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic [3:0] OWNER_HOST = 4'd8;
  localparam logic [3:0] OWNER_NONE = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               host_gnt_q, host_gnt_d;
  logic [NUM_PE-1:0]  pe_gnt_q, pe_gnt_d;
  logic [3:0]         owner_id_q, owner_id_d;
  logic               busy_q, busy_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic               pe_win_found_s;
  logic [PTR_W-1:0]   pe_win_idx_s;
  logic [PTR_W:0]     cand_s;
  logic               owner_req_s;
  logic               owner_last_s;
  logic               beat_s;
  logic               timeout_hit_s;
  logic [PTR_W-1:0]   owner_idx_s;

  // Round-robin search among PE requests, starting at rr_ptr_q and wrapping.
  always_comb begin
    pe_win_found_s = 1'b0;
    pe_win_idx_s   = '0;
    cand_s         = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      cand_s = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (cand_s >= (PTR_W+1)'(NUM_PE)) begin
        cand_s = cand_s - (PTR_W+1)'(NUM_PE);
      end else begin
        cand_s = cand_s;
      end
      if (!pe_win_found_s && pe_req_i[cand_s[PTR_W-1:0]]) begin
        pe_win_found_s = 1'b1;
        pe_win_idx_s   = cand_s[PTR_W-1:0];
      end else begin
        pe_win_found_s = pe_win_found_s;
      end
    end
  end

  // The current owner's request/last, selected by the registered grant.
  assign owner_req_s  = host_gnt_q ? host_req_i  : |(pe_req_i  & pe_gnt_q);
  assign owner_last_s = host_gnt_q ? host_last_i : |(pe_last_i & pe_gnt_q);
  assign beat_s       = (state_q == ST_GRANT) && owner_req_s;
  assign owner_idx_s  = owner_id_q[PTR_W-1:0];

  // Next-state, grant and round-robin pointer logic.
  always_comb begin
    state_d    = state_q;
    host_gnt_d = host_gnt_q;
    pe_gnt_d   = pe_gnt_q;
    owner_id_d = owner_id_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      ST_IDLE, ST_TURN: begin
        if (host_req_i) begin
          state_d    = ST_GRANT;
          host_gnt_d = 1'b1;
          pe_gnt_d   = '0;
          owner_id_d = OWNER_HOST;
        end else if (pe_win_found_s) begin
          state_d    = ST_GRANT;
          host_gnt_d = 1'b0;
          pe_gnt_d   = {{(NUM_PE-1){1'b0}}, 1'b1} << pe_win_idx_s;
          owner_id_d = 4'(pe_win_idx_s);
        end else begin
          state_d    = ST_IDLE;
          host_gnt_d = 1'b0;
          pe_gnt_d   = '0;
          owner_id_d = OWNER_NONE;
        end
      end
      ST_GRANT: begin
        if (!owner_req_s || owner_last_s || timeout_hit_s) begin
          state_d    = ST_TURN;
          host_gnt_d = 1'b0;
          pe_gnt_d   = '0;
          owner_id_d = OWNER_NONE;
          // Host bursts leave the PE rotation untouched.
          if (!host_gnt_q) begin
            rr_ptr_d = (owner_idx_s == PTR_W'(NUM_PE - 1)) ? '0 : owner_idx_s + PTR_W'(1);
          end else begin
            rr_ptr_d = rr_ptr_q;
          end
        end else begin
          state_d = ST_GRANT;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        host_gnt_d = 1'b0;
        pe_gnt_d   = '0;
        owner_id_d = OWNER_NONE;
        rr_ptr_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; grants drop asynchronously with rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      host_gnt_q <= 1'b0;
      pe_gnt_q   <= '0;
      owner_id_q <= OWNER_NONE;
      busy_q     <= 1'b0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      host_gnt_q <= host_gnt_d;
      pe_gnt_q   <= pe_gnt_d;
      owner_id_q <= owner_id_d;
      busy_q     <= busy_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

`ifdef NPU_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  logic [CNT_W-1:0] beat_cnt_q;
  logic             timeout_err_q;
  logic [3:0]       timeout_id_q;

  // Forced release on the TIMEOUT-th beat if that beat is not the last one.
  assign timeout_hit_s = beat_s && !owner_last_s &&
                         (beat_cnt_q == CNT_W'(TIMEOUT - 1));

  // Beat counter (cleared outside GRANT) and timeout report registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
      timeout_id_q  <= OWNER_NONE;
    end else begin
      if (state_q != ST_GRANT) begin
        beat_cnt_q <= '0;
      end else if (beat_s) begin
        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
      end else begin
        beat_cnt_q <= beat_cnt_q;
      end
      timeout_err_q <= timeout_hit_s;
      if (timeout_hit_s) begin
        timeout_id_q <= owner_id_q;
      end else begin
        timeout_id_q <= timeout_id_q;
      end
    end
  end

  assign timeout_err_o = timeout_err_q;
  assign timeout_id_o  = timeout_id_q;
`else
  assign timeout_hit_s = 1'b0;
  assign timeout_err_o = 1'b0;
  assign timeout_id_o  = OWNER_NONE;
`endif

  assign host_gnt_o = host_gnt_q;
  assign pe_gnt_o   = pe_gnt_q;
  assign owner_id_o = owner_id_q;
  assign busy_o     = busy_q;

endmodule

// File: doc/npu_bus_arbiter.md
# npu_bus_arbiter

Arbiter and scheduler for the NPU's shared 32-bit `data` bus. It grants bus ownership to one requester at a time: the host or one of the eight PEs that broadcast layer outputs or send results. Each grant lasts for a multi-beat burst. The block sits between the NPU sequencer/PE array and the tristate bus drivers, and guarantees one dead turnaround cycle between owners so drivers never overlap.

## Interface
- `NUM_PE`, 8: number of PE requesters; index width for `owner_id` is 4 bits.
- `TIMEOUT`, 64: maximum beats per grant before forced release; only used with `NPU_ARB_TIMEOUT_EN`.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `host_req` in 1: host requests the bus, held high for the whole burst.
- `host_last` in 1: current host beat is the final beat of its burst.
- `pe_req` in NUM_PE: per-PE bus request, held for the whole burst.
- `pe_last` in NUM_PE: per-PE final-beat flag.
- `host_gnt` out 1: host owns the bus.
- `pe_gnt` out NUM_PE: one-hot PE ownership; drives the PE output enables directly.
- `owner_id` out 4: 0..NUM_PE-1 = PE, 8 = host, 15 = none.
- `busy` out 1: high in GRANT and TURN.
- `timeout_err` out 1: one-cycle pulse on forced release.
- `timeout_id` out 4: `owner_id` of the last forced-release victim; holds until the next timeout.

## Operation
- States:
  - IDLE: no owner, arbitrating.
  - GRANT: owner drives the bus.
  - TURN: one dead cycle, arbitrating.
- Arbitration runs combinationally in IDLE and TURN.
  - The host has fixed highest priority.
  - Among PEs, round-robin starts at pointer `rr_ptr` (0..NUM_PE-1) and searches upward with wrap-around.
- Winner is registered. At the next edge the state becomes GRANT, the grant bit goes high, and `owner_id` is updated. With no requester, the state stays (TURN→IDLE).
- Beat: any GRANT cycle where the owner's req is high.
- Release from GRANT to TURN at the next edge when any of these holds:
  - owner's req high with last high (normal end);
  - owner's req low (abandon, no error);
  - timeout (see Configuration).
- On release of PE i: `rr_ptr` ← (i+1) mod NUM_PE. Host grants never move `rr_ptr`.
- Requests from non-owners during GRANT are ignored; they are only considered in TURN.
- Only one of `host_gnt`/`pe_gnt` bits may be high in any cycle. `owner_id` = 15 whenever no grant is high.
- Reset values: state IDLE, all grants 0, `owner_id` 15, `busy` 0, `rr_ptr` 0, `timeout_err` 0, `timeout_id` 15, beat counter 0.
- Reset mid-grant: all grants drop asynchronously with `rst`. No partial burst is resumed.

## Timing
- Grant latency: req sampled high at edge k in IDLE gives grant high after edge k (visible in cycle k+1).
- Single-beat burst (req and last on the first grant cycle): grant is high exactly 1 cycle.
- Owner-to-owner gap: exactly one cycle with all grants low (TURN). The next grant appears after the edge ending TURN.
- Arbitration in TURN already sees the updated `rr_ptr`.
- `busy` is registered with state and has no combinational path from req.
- `timeout_err` rises on the same edge as the forced GRANT→TURN transition and falls the following edge.

## Configuration
- `NPU_ARB_TIMEOUT_EN` defined:
  - A beat counter (width clog2(TIMEOUT)+1) clears on entry to GRANT and increments each beat.
  - When it reaches TIMEOUT without last, the next edge forces GRANT→TURN, pulses `timeout_err`, latches `timeout_id` ← `owner_id`, and advances `rr_ptr` as for a normal release.
  - A last on beat TIMEOUT is a normal release with no error.
- Undefined: no counter is built; grants are unbounded; `timeout_err` is tied 0 and `timeout_id` is tied 15.

## Test plan
- Reset: assert `rst` with random inputs → all grants 0, `owner_id`=15, `busy`=0, `timeout_id`=15. Deassert with no reqs → outputs unchanged.
- Simultaneous PE requests: from reset, PE2 and PE5 raise req at the same edge, each with last on beat 3 → `pe_gnt`=0x04 for 3 cycles, 1 cycle all-zero, then `pe_gnt`=0x20 for 3 cycles; `owner_id` sequence 2,15,5.
- Host priority: host and PE0 request at the same edge → `host_gnt` first, `owner_id`=8. PE0 is granted after TURN, and `rr_ptr` is unchanged by the host burst.
- Round-robin wrap: PE7 completes a burst, then PE0 and PE7 both request → PE0 is granted (`rr_ptr` wrapped to 0).
- Abandon: PE3 granted, drops req on beat 2 without last → TURN next cycle, `timeout_err` stays 0, `rr_ptr`=4.
- Timeout (macro defined, TIMEOUT=8): PE6 holds req and never asserts last → grant lasts 8 cycles, `timeout_err` pulses 1 cycle, `timeout_id`=6. With the macro undefined, the grant persists.
